// File: rtl/rst_intc.sv
// rst_intc -- priority interrupt controller for an i8080-style CPU.
//
// Eight asynchronous requests are synchronised, edge-latched into a pending
// register and prioritised against a mask and an in-service register.
// `intr` goes to the CPU. During the INTA read the block drives an RST n
// opcode ({2'b11, n, 3'b111}).
//
// Ports
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   ce        CPU clock enable; all state updates are qualified by it
//   addr      register select: 0 = mask (wr) / pending (rd),
//                              1 = EOI (wr) / in-service (rd)
//   data_in   CPU write data
//   rd, we    I/O read / write strobes for this block's two ports
//   ack       high while the CPU reads in an INTA machine cycle
//   data_out  register read data, or the RST opcode while ack is high
//   irq[7:0]  asynchronous requests, irq[7] highest priority
//   intr      registered interrupt request to the CPU
//
// Handshake: ack is a level that spans the whole INTA read. The first ce
// cycle with ack=1 freezes the vector. The first ce cycle with ack=0
// afterwards commits it.
//
// Build option: define RST_INTC_LEVEL_EN for level-sensitive inputs. In that
// build pending simply tracks the synchronised request, and only isr
// suppresses a source until EOI.

module rst_intc #(
    parameter int          IRQ_SYNC_STAGES = 2,
    parameter logic [7:0]  RESET_MASK      = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       addr,
    input  logic [7:0] data_in,
    input  logic       rd,
    input  logic       we,
    input  logic       ack,
    output logic [7:0] data_out,
    input  logic [7:0] irq,
    output logic       intr
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_t;

    ack_state_t state_q, state_d;

    logic [7:0] sync_q [IRQ_SYNC_STAGES];
    logic [7:0] sync_out;
    logic [7:0] pending_q, pending_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] mask_q, mask_d;
    logic       intr_d;
    logic [2:0] vec_q;
    logic       spurious_q;
    logic [7:0] data_q;
    logic [7:0] elig_cur;
    logic       load_vec;
    logic       commit;

    // Eligible requests: unmasked pending bits strictly above the highest
    // in-service bit (every bit when nothing is in service).
    function automatic logic [7:0] elig_f(input logic [7:0] p,
                                          input logic [7:0] m,
                                          input logic [7:0] s);
        logic [7:0] keep;
        keep = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) keep = 8'hFF << (i + 1);
        end
        return p & ~m & keep;
    endfunction

    // Index of the highest set bit. An empty vector yields 7, so a
    // spurious acknowledge naturally reads back as RST 7 (8'hFF).
    function automatic logic [2:0] prio_f(input logic [7:0] e);
        logic [2:0] idx;
        idx = 3'd7;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    assign sync_out = sync_q[IRQ_SYNC_STAGES-1];
    assign elig_cur = elig_f(pending_q, mask_q, isr_q);
    assign load_vec = ce && (state_q == ST_IDLE) && ack;
    assign commit   = ce && (state_q == ST_ACK) && !ack && !spurious_q;

    // Request synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < IRQ_SYNC_STAGES; i++) sync_q[i] <= 8'h00;
        end else if (ce) begin
            sync_q[0] <= irq;
            for (int i = 1; i < IRQ_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef RST_INTC_LEVEL_EN
    // Level build: pending follows the synchronised request.
    always_comb begin
        pending_d = pending_q;
        if (ce) pending_d = sync_out;
    end
`else
    logic [7:0] sync_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  sync_prev_q <= 8'h00;
        else if (ce)   sync_prev_q <= sync_out;
    end

    // Edge build: commit clears the acknowledged bit. A new edge in the same
    // cycle is applied afterwards so that the set wins.
    always_comb begin
        pending_d = pending_q;
        if (commit) pending_d[vec_q] = 1'b0;
        if (ce)     pending_d = pending_d | (sync_out & ~sync_prev_q);
    end
`endif

    // Mask, in-service and intr next state. EOI is applied before commit so
    // that a commit on the same bit leaves it in service.
    always_comb begin
        mask_d = mask_q;
        isr_d  = isr_q;
        intr_d = intr;
        if (ce && we && !addr) mask_d = data_in;
        if (ce && we && addr) begin
            if (data_in[7]) begin
                if (isr_q != 8'h00) isr_d[prio_f(isr_q)] = 1'b0;
            end else begin
                isr_d[data_in[2:0]] = 1'b0;
            end
        end
        if (commit) isr_d[vec_q] = 1'b1;
        if (ce) intr_d = |elig_f(pending_d, mask_d, isr_d);
    end

    // Acknowledge FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ce && ack)  state_d = ST_ACK;
            ST_ACK:  if (ce && !ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= 8'h00;
            isr_q      <= 8'h00;
            mask_q     <= RESET_MASK;
            intr       <= 1'b0;
            vec_q      <= 3'd0;
            spurious_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            isr_q     <= isr_d;
            mask_q    <= mask_d;
            intr      <= intr_d;
            if (load_vec) begin
                vec_q      <= prio_f(elig_cur);
                spurious_q <= (elig_cur == 8'h00);
            end
        end
    end

    // Read mux. Before the FSM has entered ACK, the opcode is shown live
    // from the current eligible set. That is the same value that is frozen
    // into vec on the transition, so the read stays stable throughout.
    always_comb begin
        data_out = data_q;
        if (ack) begin
            if (state_q == ST_ACK)
                data_out = {2'b11, (spurious_q ? 3'd7 : vec_q), 3'b111};
            else
                data_out = {2'b11, prio_f(elig_cur), 3'b111};
        end else if (rd) begin
            data_out = addr ? isr_q : pending_q;
        end
    end

    // Holds the last driven value while nothing is being read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_q <= 8'h00;
        else          data_q <= data_out;
    end

endmodule

// File: tb/tb_rst_intc.sv
module tb_rst_intc;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic       addr;
  logic [7:0] data_in;
  logic       rd;
  logic       we;
  logic       ack;
  logic [7:0] data_out;
  logic [7:0] irq;
  logic       intr;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  rst_intc #(.IRQ_SYNC_STAGES(2), .RESET_MASK(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .addr(addr), .data_in(data_in),
    .rd(rd), .we(we), .ack(ack), .data_out(data_out), .irq(irq), .intr(intr)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // scoreboard compare: pops the oldest expectation
  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input logic a, input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    addr = a; rd = 1'b1;
    #1 check(tag, data_out);
    tick();
    rd = 1'b0;
  endtask

  task automatic wr_reg(input logic a, input logic [7:0] d);
    addr = a; data_in = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic pulse_irq(input logic [7:0] bits);
    irq = irq | bits;
    repeat (3) tick();
    irq = irq & ~bits;
  endtask

  task automatic wait_intr(input logic exp, input string tag);
    for (int i = 0; i < 10; i++) begin
      if (intr === exp) break;
      tick();
    end
    exp_q.push_back({7'd0, exp});
    check(tag, {7'd0, intr});
  endtask

  task automatic chk_intr(input logic exp, input string tag);
    exp_q.push_back({7'd0, exp});
    #1 check(tag, {7'd0, intr});
  endtask

  // full INTA read: opcode on entry, still stable in ACK, held after release
  task automatic inta(input logic [7:0] op, input string tag);
    exp_q.push_back(op); exp_q.push_back(op); exp_q.push_back(op);
    rd = 1'b1; ack = 1'b1;
    #1 check({tag, "_entry"}, data_out);
    tick();
    #1 check({tag, "_ack"}, data_out);
    tick();
    ack = 1'b0; rd = 1'b0;
    tick();
    #1 check({tag, "_hold"}, data_out);
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; addr = 1'b0; data_in = 8'h00;
    rd = 1'b0; we = 1'b0; ack = 1'b0; irq = 8'h00;
    repeat (2) tick();
    chk_intr(1'b0, "rst_intr");
    exp_q.push_back(8'h00);
    check("rst_dout", data_out);
    reset_n = 1'b1;
    tick();

`ifndef RST_INTC_LEVEL_EN
    rd_reg(1'b0, 8'h00, "rst_pending");
    chk_intr(1'b0, "rst_intr2");

    // single request
    wr_reg(1'b0, 8'h00);
    pulse_irq(8'h08);
    wait_intr(1'b1, "irq3_intr");
    rd_reg(1'b0, 8'h08, "irq3_pending");
    inta(8'hDF, "irq3_inta");
    rd_reg(1'b1, 8'h08, "irq3_isr");
    chk_intr(1'b0, "irq3_intr_off");
    wr_reg(1'b1, 8'h03);
    rd_reg(1'b1, 8'h00, "irq3_eoi");

    // two requests, higher wins
    pulse_irq(8'h24);
    wait_intr(1'b1, "irq25_intr");
    inta(8'hEF, "irq25_inta");
    chk_intr(1'b0, "irq25_intr_blocked");
    rd_reg(1'b0, 8'h04, "irq25_pending");
    rd_reg(1'b1, 8'h20, "irq25_isr");

    // nesting and EOI variants
    pulse_irq(8'h40);
    wait_intr(1'b1, "irq6_intr");
    inta(8'hF7, "irq6_inta");
    rd_reg(1'b1, 8'h60, "irq6_isr");
    wr_reg(1'b1, 8'h80);
    rd_reg(1'b1, 8'h20, "ns_eoi_isr");
    chk_intr(1'b0, "ns_eoi_intr");
    wr_reg(1'b1, 8'h05);
    wait_intr(1'b1, "sp_eoi_intr");
    rd_reg(1'b1, 8'h00, "sp_eoi_isr");
    inta(8'hD7, "irq2_inta");
    rd_reg(1'b0, 8'h00, "irq2_pending");
    wr_reg(1'b1, 8'h80);
    rd_reg(1'b1, 8'h00, "irq2_eoi");

    // masked request and spurious ack
    wr_reg(1'b0, 8'hFF);
    pulse_irq(8'h10);
    repeat (3) tick();
    chk_intr(1'b0, "masked_intr");
    rd_reg(1'b0, 8'h10, "masked_pending");
    inta(8'hFF, "spurious_inta");
    rd_reg(1'b1, 8'h00, "spurious_isr");
    rd_reg(1'b0, 8'h10, "spurious_pending");

    // reset during ACK
    wr_reg(1'b0, 8'h00);
    wait_intr(1'b1, "pre_rst_intr");
    rd = 1'b1; ack = 1'b1;
    tick();
    reset_n = 1'b0; ack = 1'b0; rd = 1'b0;
    chk_intr(1'b0, "midack_intr");
    exp_q.push_back(8'h00);
    check("midack_dout", data_out);
    tick();
    reset_n = 1'b1;
    tick();
    rd_reg(1'b0, 8'h00, "midack_pending");
    rd_reg(1'b1, 8'h00, "midack_isr");

    // mask is back to all-ones; irq[0] gives RST 0
    pulse_irq(8'h01);
    repeat (2) tick();
    chk_intr(1'b0, "rstmask_intr");
    wr_reg(1'b0, 8'h00);
    wait_intr(1'b1, "irq0_intr");
    inta(8'hC7, "irq0_inta");

    // new edge on the acknowledged bit in the commit cycle
    pulse_irq(8'h02);
    wait_intr(1'b1, "irq1_intr");
    repeat (3) tick();
    exp_q.push_back(8'hCF);
    rd = 1'b1; ack = 1'b1;
    tick();
    #1 check("reedge_ack", data_out);
    irq[1] = 1'b1;
    repeat (2) tick();
    ack = 1'b0; rd = 1'b0;
    tick();
    irq[1] = 1'b0;
    rd_reg(1'b1, 8'h03, "reedge_isr");
    rd_reg(1'b0, 8'h02, "reedge_pending");
    chk_intr(1'b0, "reedge_intr");
`else
    // level-sensitive: held request stays pending, blocked by isr until EOI
    wr_reg(1'b0, 8'h00);
    irq[1] = 1'b1;
    wait_intr(1'b1, "lvl_intr");
    inta(8'hCF, "lvl_inta");
    rd_reg(1'b0, 8'h02, "lvl_pending");
    rd_reg(1'b1, 8'h02, "lvl_isr");
    chk_intr(1'b0, "lvl_intr_blocked");
    wr_reg(1'b1, 8'h01);
    wait_intr(1'b1, "lvl_eoi_intr");
    irq[1] = 1'b0;
    wait_intr(1'b0, "lvl_release_intr");
    rd_reg(1'b0, 8'h00, "lvl_release_pending");
    rd_reg(1'b1, 8'h00, "lvl_release_isr");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
